alu_operand_issue: RTL and testbench

- ID/EX boundary stage of the 5-stage RISC-V pipeline. It registers decoded instructions and drives the EX-stage ALU's ALUCode, A and B.
- It resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages, and inserts a bubble on a load-use dependency.
- It handles flush (taken branch/jump) and a global pipeline hold.

---
 rtl/alu_operand_issue_if.sv | 64 ++++++
 rtl/alu_operand_issue.sv | 129 ++++++++++++
 tb/tb_alu_operand_issue.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_issue_if.sv
// ID/EX issue bundle: decoded ID fields, forwarding sources and EX-side ALU operands.
interface alu_operand_issue_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    logic               hold;
    logic               flush;
    logic               id_valid;
    logic [3:0]         id_ALUCode;
    logic               id_ALUSrcA;
    logic               id_ALUSrcB;
    logic               id_useRs1;
    logic               id_useRs2;
    logic [RADDR_W-1:0] id_rs1Addr;
    logic [RADDR_W-1:0] id_rs2Addr;
    logic [RADDR_W-1:0] id_rdAddr;
    logic [XLEN-1:0]    id_rs1Data;
    logic [XLEN-1:0]    id_rs2Data;
    logic [XLEN-1:0]    id_imm;
    logic [XLEN-1:0]    id_pc;
    logic               id_RegWrite;
    logic               id_MemRead;
    logic               id_MemWrite;
    logic               exmem_RegWrite;
    logic [RADDR_W-1:0] exmem_rdAddr;
    logic [XLEN-1:0]    exmem_ALUResult;
    logic               memwb_RegWrite;
    logic [RADDR_W-1:0] memwb_rdAddr;
    logic [XLEN-1:0]    memwb_WriteData;

    logic               id_stall;
    logic [3:0]         ALUCode;
    logic [XLEN-1:0]    A;
    logic [XLEN-1:0]    B;
    logic [XLEN-1:0]    ex_StoreData;
    logic               ex_valid;
    logic               ex_RegWrite;
    logic               ex_MemRead;
    logic               ex_MemWrite;
    logic [RADDR_W-1:0] ex_rdAddr;
    logic [15:0]        bubble_cnt;

    modport master (
        output hold, flush, id_valid, id_ALUCode, id_ALUSrcA, id_ALUSrcB,
               id_useRs1, id_useRs2, id_rs1Addr, id_rs2Addr, id_rdAddr,
               id_rs1Data, id_rs2Data, id_imm, id_pc,
               id_RegWrite, id_MemRead, id_MemWrite,
               exmem_RegWrite, exmem_rdAddr, exmem_ALUResult,
               memwb_RegWrite, memwb_rdAddr, memwb_WriteData,
        input  id_stall, ALUCode, A, B, ex_StoreData, ex_valid,
               ex_RegWrite, ex_MemRead, ex_MemWrite, ex_rdAddr, bubble_cnt
    );

    modport slave (
        input  hold, flush, id_valid, id_ALUCode, id_ALUSrcA, id_ALUSrcB,
               id_useRs1, id_useRs2, id_rs1Addr, id_rs2Addr, id_rdAddr,
               id_rs1Data, id_rs2Data, id_imm, id_pc,
               id_RegWrite, id_MemRead, id_MemWrite,
               exmem_RegWrite, exmem_rdAddr, exmem_ALUResult,
               memwb_RegWrite, memwb_rdAddr, memwb_WriteData,
        output id_stall, ALUCode, A, B, ex_StoreData, ex_valid,
               ex_RegWrite, ex_MemRead, ex_MemWrite, ex_rdAddr, bubble_cnt
    );
endinterface

// File: rtl/alu_operand_issue.sv
// ID/EX stage register with EX/MEM + MEM/WB operand forwarding and load-use bubbling.
// Optional load-use bubble counter enabled by defining ALU_ISSUE_BUBBLE_CNT_EN.
module alu_operand_issue #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_operand_issue_if.slave   bus
);
    typedef struct packed {
        logic               valid;
        logic [3:0]         alu_code;
        logic               src_a;
        logic               src_b;
        logic [RADDR_W-1:0] rs1_addr;
        logic [RADDR_W-1:0] rs2_addr;
        logic [RADDR_W-1:0] rd_addr;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    pc;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
    } stage_t;

    stage_t stage_reg;
    stage_t stage_next;
    logic   rs1_hit;
    logic   rs2_hit;
    logic   lu;

    assign rs1_hit = bus.id_useRs1 && (bus.id_rs1Addr == stage_reg.rd_addr);
    assign rs2_hit = bus.id_useRs2 && (bus.id_rs2Addr == stage_reg.rd_addr);
    assign lu      = bus.id_valid && stage_reg.valid && stage_reg.mem_read &&
                     (stage_reg.rd_addr != '0) && (rs1_hit || rs2_hit);
    assign bus.id_stall = lu && !bus.flush;

    // A bubble zeroes every field so its operands resolve to 0 through x0.
    always_comb begin
        stage_next = stage_reg;
        if (bus.flush) begin
            stage_next = '0;
        end else if (bus.hold) begin
            stage_next = stage_reg;
        end else if (lu || !bus.id_valid) begin
            stage_next = '0;
        end else begin
            stage_next.valid     = 1'b1;
            stage_next.alu_code  = bus.id_ALUCode;
            stage_next.src_a     = bus.id_ALUSrcA;
            stage_next.src_b     = bus.id_ALUSrcB;
            stage_next.rs1_addr  = bus.id_rs1Addr;
            stage_next.rs2_addr  = bus.id_rs2Addr;
            stage_next.rd_addr   = bus.id_rdAddr;
            stage_next.rs1_data  = bus.id_rs1Data;
            stage_next.rs2_data  = bus.id_rs2Data;
            stage_next.imm       = bus.id_imm;
            stage_next.pc        = bus.id_pc;
            stage_next.reg_write = bus.id_RegWrite;
            stage_next.mem_read  = bus.id_MemRead;
            stage_next.mem_write = bus.id_MemWrite;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= stage_next;
        end
    end

    logic [1:0][RADDR_W-1:0] src_addr;
    logic [1:0][XLEN-1:0]    src_data;
    logic [1:0][XLEN-1:0]    fwd;

    assign src_addr[0] = stage_reg.rs1_addr;
    assign src_addr[1] = stage_reg.rs2_addr;
    assign src_data[0] = stage_reg.rs1_data;
    assign src_data[1] = stage_reg.rs2_data;

    // EX/MEM is checked first since it holds the younger producer.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd[gi] =
                (src_addr[gi] == '0) ? '0 :
                (bus.exmem_RegWrite && (bus.exmem_rdAddr == src_addr[gi])) ? bus.exmem_ALUResult :
                (bus.memwb_RegWrite && (bus.memwb_rdAddr == src_addr[gi])) ? bus.memwb_WriteData :
                src_data[gi];
        end
    endgenerate

    assign bus.ALUCode      = stage_reg.alu_code;
    assign bus.A            = stage_reg.src_a ? stage_reg.pc  : fwd[0];
    assign bus.B            = stage_reg.src_b ? stage_reg.imm : fwd[1];
    assign bus.ex_StoreData = fwd[1];
    assign bus.ex_valid     = stage_reg.valid;
    assign bus.ex_RegWrite  = stage_reg.reg_write;
    assign bus.ex_MemRead   = stage_reg.mem_read;
    assign bus.ex_MemWrite  = stage_reg.mem_write;
    assign bus.ex_rdAddr    = stage_reg.rd_addr;

`ifdef ALU_ISSUE_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_reg;
    logic [15:0] bubble_cnt_next;

    always_comb begin
        bubble_cnt_next = bubble_cnt_reg;
        if (lu && !bus.flush && !bus.hold && (bubble_cnt_reg != 16'hFFFF)) begin
            bubble_cnt_next = bubble_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_reg <= '0;
        end else begin
            bubble_cnt_reg <= bubble_cnt_next;
        end
    end

    assign bus.bubble_cnt = bubble_cnt_reg;
`else
    assign bus.bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_operand_issue.sv
// Randomized + directed bench for alu_operand_issue against an instruction-level model.
module tb_alu_operand_issue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    alu_operand_issue_if #(.XLEN(32), .RADDR_W(5)) bus ();

    alu_operand_issue #(.XLEN(32), .RADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Model of the instruction currently sitting in EX.
    typedef struct {
        bit        valid;
        bit [3:0]  code;
        bit        sa, sb;
        bit [4:0]  rs1, rs2, rd;
        bit [31:0] d1, d2, imm, pc;
        bit        rw, mr, mw;
    } instr_t;

    instr_t    ex_m;
    bit [15:0] cnt_m;

    function automatic instr_t nop_instr();
        instr_t n;
        n = '{default: 0};
        return n;
    endfunction

    function automatic bit [31:0] operand(input bit [4:0] r, input bit [31:0] stale);
        if (r == 0) return 32'h0;
        if (bus.exmem_RegWrite && bus.exmem_rdAddr == r) return bus.exmem_ALUResult;
        if (bus.memwb_RegWrite && bus.memwb_rdAddr == r) return bus.memwb_WriteData;
        return stale;
    endfunction

    function automatic bit load_use();
        bit dep;
        dep = (bus.id_useRs1 && bus.id_rs1Addr == ex_m.rd) ||
              (bus.id_useRs2 && bus.id_rs2Addr == ex_m.rd);
        return bus.id_valid && ex_m.valid && ex_m.mr && ex_m.rd != 0 && dep;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        bit [31:0] f1, f2;
        f1 = operand(ex_m.rs1, ex_m.d1);
        f2 = operand(ex_m.rs2, ex_m.d2);
        check("id_stall", bus.id_stall, load_use() && !bus.flush);
        check("ALUCode", bus.ALUCode, ex_m.code);
        check("A", bus.A, ex_m.sa ? ex_m.pc : f1);
        check("B", bus.B, ex_m.sb ? ex_m.imm : f2);
        check("StoreData", bus.ex_StoreData, f2);
        check("ex_valid", bus.ex_valid, ex_m.valid);
        check("ex_RegWrite", bus.ex_RegWrite, ex_m.rw);
        check("ex_MemRead", bus.ex_MemRead, ex_m.mr);
        check("ex_MemWrite", bus.ex_MemWrite, ex_m.mw);
        check("ex_rdAddr", bus.ex_rdAddr, ex_m.rd);
        check("bubble_cnt", bus.bubble_cnt, cnt_m);
    endtask

    task automatic model_edge();
        bit lu;
        lu = load_use();
        if (bus.flush) begin
            ex_m = nop_instr();
        end else if (bus.hold) begin
            ex_m = ex_m;
        end else if (lu) begin
            ex_m = nop_instr();
`ifdef ALU_ISSUE_BUBBLE_CNT_EN
            if (cnt_m != 16'hFFFF) cnt_m++;
`endif
        end else if (!bus.id_valid) begin
            ex_m = nop_instr();
        end else begin
            ex_m.valid = 1;
            ex_m.code = bus.id_ALUCode;
            ex_m.sa = bus.id_ALUSrcA;   ex_m.sb = bus.id_ALUSrcB;
            ex_m.rs1 = bus.id_rs1Addr;  ex_m.rs2 = bus.id_rs2Addr;
            ex_m.rd = bus.id_rdAddr;
            ex_m.d1 = bus.id_rs1Data;   ex_m.d2 = bus.id_rs2Data;
            ex_m.imm = bus.id_imm;      ex_m.pc = bus.id_pc;
            ex_m.rw = bus.id_RegWrite;  ex_m.mr = bus.id_MemRead;
            ex_m.mw = bus.id_MemWrite;
        end
    endtask

    // Inputs are set at the negedge; check, clock, update model, return at next negedge.
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_id(input bit v, input bit [3:0] code, input bit sa, input bit sb,
                          input bit u1, input bit u2, input bit [4:0] r1, input bit [4:0] r2,
                          input bit [4:0] rd, input bit [31:0] d1, input bit [31:0] d2,
                          input bit [31:0] imm, input bit [31:0] pc,
                          input bit rw, input bit mr, input bit mw);
        bus.id_valid = v;     bus.id_ALUCode = code;
        bus.id_ALUSrcA = sa;  bus.id_ALUSrcB = sb;
        bus.id_useRs1 = u1;   bus.id_useRs2 = u2;
        bus.id_rs1Addr = r1;  bus.id_rs2Addr = r2;  bus.id_rdAddr = rd;
        bus.id_rs1Data = d1;  bus.id_rs2Data = d2;
        bus.id_imm = imm;     bus.id_pc = pc;
        bus.id_RegWrite = rw; bus.id_MemRead = mr;  bus.id_MemWrite = mw;
    endtask

    task automatic set_fwd(input bit erw, input bit [4:0] erd, input bit [31:0] eres,
                           input bit wrw, input bit [4:0] wrd, input bit [31:0] wdat);
        bus.exmem_RegWrite = erw; bus.exmem_rdAddr = erd; bus.exmem_ALUResult = eres;
        bus.memwb_RegWrite = wrw; bus.memwb_rdAddr = wrd; bus.memwb_WriteData = wdat;
    endtask

    task automatic idle_id();
        set_id(0, 4'h0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    endtask

    initial begin
        bit [15:0] cnt_before;
        ex_m = nop_instr();
        cnt_m = 16'h0;
        bus.hold = 0;
        bus.flush = 0;
        idle_id();
        set_fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        repeat (2) @(negedge clk);
        check("reset_A", bus.A, 32'h0);
        check("reset_valid", bus.ex_valid, 1'b0);
        rst_n = 1'b1;

        // Back-to-back EX/MEM forward.
        set_id(1, 4'h0, 0, 0, 1, 1, 5'd1, 5'd2, 5'd5, 32'h10, 32'h20, 32'h0, 32'h0, 1, 0, 0);
        step();
        set_id(1, 4'h1, 0, 0, 1, 1, 5'd5, 5'd3, 5'd6, 32'h0, 32'h5, 32'h0, 32'h0, 1, 0, 0);
        step();
        idle_id();
        set_fwd(1, 5'd5, 32'h30, 0, 5'd0, 32'h0);
        #1;
        check("b2b_A", bus.A, 32'h30);
        check("b2b_ALUCode", bus.ALUCode, 4'h1);
        check("b2b_stall", bus.id_stall, 1'b0);
        step();

        // Double hazard: EX/MEM wins over MEM/WB.
        set_fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        set_id(1, 4'h0, 0, 0, 1, 0, 5'd7, 5'd0, 5'd10, 32'h99, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        step();
        idle_id();
        set_fwd(1, 5'd7, 32'h11, 1, 5'd7, 32'h22);
        #1;
        check("double_A", bus.A, 32'h11);
        step();

        // Load-use: one stall cycle, one bubble, then MEM/WB forward.
        set_fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        cnt_before = cnt_m;
        set_id(1, 4'h0, 0, 1, 1, 0, 5'd2, 5'd0, 5'd8, 32'h100, 32'h0, 32'h4, 32'h0, 1, 1, 0);
        step();
        set_id(1, 4'h7, 0, 0, 1, 1, 5'd8, 5'd4, 5'd9, 32'h0, 32'h3, 32'h0, 32'h0, 1, 0, 0);
        #1;
        check("lu_stall_hi", bus.id_stall, 1'b1);
        step();
        #1;
        check("lu_stall_lo", bus.id_stall, 1'b0);
        check("lu_bubble_valid", bus.ex_valid, 1'b0);
        check("lu_bubble_code", bus.ALUCode, 4'h0);
        step();
        idle_id();
        set_fwd(0, 5'd0, 32'h0, 1, 5'd8, 32'hDEAD_BEEF);
        #1;
        check("lu_A", bus.A, 32'hDEAD_BEEF);
        check("lu_code", bus.ALUCode, 4'h7);
`ifdef ALU_ISSUE_BUBBLE_CNT_EN
        check("lu_cnt", bus.bubble_cnt, cnt_before + 16'd1);
`else
        check("lu_cnt", bus.bubble_cnt, cnt_before);
`endif
        step();

        // x0 is never forwarded.
        set_fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        set_id(1, 4'h0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd11, 32'h55, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        step();
        idle_id();
        set_fwd(1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 32'hFFFF_FFFF);
        #1;
        check("x0_A", bus.A, 32'h0);
        step();

        // Flush beats hold and load-use.
        set_fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        set_id(1, 4'h0, 0, 1, 1, 0, 5'd1, 5'd0, 5'd9, 32'h0, 32'h0, 32'h8, 32'h0, 1, 1, 0);
        step();
        cnt_before = cnt_m;
        set_id(1, 4'h2, 0, 0, 1, 0, 5'd9, 5'd0, 5'd12, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        bus.flush = 1;
        bus.hold = 1;
        #1;
        check("flush_stall", bus.id_stall, 1'b0);
        step();
        bus.flush = 0;
        bus.hold = 0;
        #1;
        check("flush_valid", bus.ex_valid, 1'b0);
        check("flush_cnt", bus.bubble_cnt, cnt_before);

        // Hold freezes an auipc-style instruction for three cycles.
        set_id(1, 4'h0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd13, 32'h0, 32'h0, 32'h2000, 32'h4444, 1, 0, 0);
        step();
        bus.hold = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 4'h3, 0, 0, 1, 1, 5'(i + 1), 5'd2, 5'd14, 32'h7, 32'h7, 32'h0, 32'h0, 1, 0, 0);
            #1;
            check("hold_A", bus.A, 32'h4444);
            check("hold_B", bus.B, 32'h2000);
            step();
        end
        bus.hold = 0;

        // PC/immediate select, then an asynchronous reset pulse.
        set_id(1, 4'h0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd15, 32'h0, 32'h0, 32'h2000, 32'h1000, 1, 0, 0);
        step();
        idle_id();
        #1;
        check("auipc_A", bus.A, 32'h1000);
        check("auipc_B", bus.B, 32'h2000);
        rst_n = 1'b0;
        #1;
        check("arst_A", bus.A, 32'h0);
        check("arst_B", bus.B, 32'h0);
        check("arst_valid", bus.ex_valid, 1'b0);
        check("arst_cnt", bus.bubble_cnt, 16'h0);
        ex_m = nop_instr();
        cnt_m = 16'h0;
        rst_n = 1'b1;
        step();

        // Random traffic over a small register window to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            set_id($urandom_range(0, 99) < 85, 4'($urandom_range(0, 10)),
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                   1'($urandom), 1'($urandom),
                   5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)),
                   $urandom, $urandom, $urandom, $urandom,
                   1'($urandom), $urandom_range(0, 99) < 35, 1'($urandom_range(0, 3) == 0));
            set_fwd(1'($urandom), 5'($urandom_range(0, 6)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 6)), $urandom);
            bus.hold = $urandom_range(0, 99) < 10;
            bus.flush = $urandom_range(0, 99) < 8;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
